// File: rtl/jesd204_sysref_gen_pkg.sv
// Shared types, widths and helpers for the JESD204 SYSREF generator.
package jesd204_sysref_gen_pkg;

   localparam int BEAT_W   = 8;
   localparam int CNT_W    = 8;
   localparam int WIDTH_W  = 4;
   localparam int PERIOD_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      PULSE = 2'd2,
      GAP   = 2'd3
   } state_t;

   // Wraps on >= so a shrinking multiframe length can never strand the counter.
   function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] beat,
                                                  input logic [BEAT_W-1:0] last);
      return (beat >= last) ? '0 : beat + 1'b1;
   endfunction

endpackage

// File: rtl/jesd204_sysref_gen_sync.sv
// Multi-flop synchronizer for the asynchronous external trigger plus rising-edge detect.
module jesd204_sysref_gen_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign sync_d[gi] = async_in;
         end else begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   always_comb begin
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jesd204_sysref_gen.sv
// JESD204 SYSREF burst generator aligned to a free-running LMFC beat counter.
// Define JESD204_SYSREF_GEN_EXT_TRIG_EN to add the asynchronous ext_trigger start input.
module jesd204_sysref_gen
   import jesd204_sysref_gen_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [BEAT_W-1:0]   cfg_beats_per_multiframe,
   input  logic [BEAT_W-1:0]   cfg_sysref_offset,
   input  logic [WIDTH_W-1:0]  cfg_pulse_width,
   input  logic [PERIOD_W-1:0] cfg_mf_per_pulse,
   input  logic [CNT_W-1:0]    cfg_pulse_count,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic                stop,
`ifdef JESD204_SYSREF_GEN_EXT_TRIG_EN
   input  logic                ext_trigger,
`endif
   output logic                sysref,
   output logic                lmfc_edge,
   output logic [BEAT_W-1:0]   beat_counter,
   output logic                busy,
   output logic                burst_done,
   output logic [CNT_W-1:0]    pulse_index
);

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [WIDTH_W-1:0]  width_cnt_q, width_cnt_d;
   logic [PERIOD_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]    pulse_index_q, pulse_index_d;
   logic                stop_pend_q, stop_pend_d;
   logic                sysref_q, sysref_d;
   logic                lmfc_q, lmfc_d;
   logic                burst_done_q, burst_done_d;
   logic [CNT_W-1:0]    idx_inc;
   logic                align, align_next, trig_rise, start_req;

`ifdef JESD204_SYSREF_GEN_EXT_TRIG_EN
   jesd204_sysref_gen_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ext_trigger),
      .rise     (trig_rise)
   );
`else
   // SYNC_STAGES only matters when the external trigger is built in.
   logic unused_sync_cfg;
   assign unused_sync_cfg = (SYNC_STAGES > 0);
   assign trig_rise       = 1'b0;
`endif

   always_comb begin
      beat_d        = beat_inc(beat_q, cfg_beats_per_multiframe);
      align         = (beat_q == cfg_sysref_offset);
      align_next    = (beat_d == cfg_sysref_offset);
      lmfc_d        = (beat_q == '0);
      start_req     = start_valid | trig_rise;
      idx_inc       = (pulse_index_q == '1) ? pulse_index_q : pulse_index_q + 1'b1;
      state_d       = state_q;
      width_cnt_d   = width_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      pulse_index_d = pulse_index_q;
      stop_pend_d   = stop_pend_q;

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            if (start_req && !stop) begin
               state_d       = ARMED;
               pulse_index_d = '0;
            end
         end
         ARMED: begin
            if (stop) begin
               state_d = IDLE;
            end else if (align) begin
               state_d     = PULSE;
               width_cnt_d = '0;
               gap_cnt_d   = '0;
            end
         end
         PULSE: begin
            width_cnt_d = width_cnt_q + 1'b1;
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            // Ending one cycle before an alignment point keeps a low cycle ahead of the next rise.
            if (width_cnt_q >= cfg_pulse_width || align_next) begin
               pulse_index_d = idx_inc;
               if (stop || stop_pend_q ||
                   (cfg_pulse_count != '0 && idx_inc >= cfg_pulse_count)) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_d = IDLE;
            end else if (align) begin
               if (gap_cnt_q >= cfg_mf_per_pulse) begin
                  state_d     = PULSE;
                  width_cnt_d = '0;
                  gap_cnt_d   = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      sysref_d     = (state_d == PULSE);
      burst_done_d = (state_q != IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         width_cnt_q   <= '0;
         gap_cnt_q     <= '0;
         pulse_index_q <= '0;
         stop_pend_q   <= 1'b0;
         sysref_q      <= 1'b0;
         lmfc_q        <= 1'b0;
         burst_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         width_cnt_q   <= width_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         pulse_index_q <= pulse_index_d;
         stop_pend_q   <= stop_pend_d;
         sysref_q      <= sysref_d;
         lmfc_q        <= lmfc_d;
         burst_done_q  <= burst_done_d;
      end
   end

   assign start_ready  = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign sysref       = sysref_q;
   assign lmfc_edge    = lmfc_q;
   assign beat_counter = beat_q;
   assign burst_done   = burst_done_q;
   assign pulse_index  = pulse_index_q;

endmodule

// File: tb/tb_jesd204_sysref_gen.sv
// Directed bench for jesd204_sysref_gen; a pulse monitor checks each SYSREF pulse against a queue
// of expected pulses (rise beat, length, spacing). Define JESD204_SYSREF_GEN_EXT_TRIG_EN for ext_trigger.
module tb_jesd204_sysref_gen;

   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] cfg_beats_per_multiframe, cfg_sysref_offset, cfg_pulse_count;
   logic [3:0] cfg_pulse_width, cfg_mf_per_pulse;
   logic       start_valid, start_ready, stop;
   logic       sysref, lmfc_edge, busy, burst_done;
   logic [7:0] beat_counter, pulse_index;
`ifdef JESD204_SYSREF_GEN_EXT_TRIG_EN
   logic       ext_trigger = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      int rise_beat;
      int len;
      int spacing;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   jesd204_sysref_gen #(.SYNC_STAGES(SS)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .cfg_beats_per_multiframe (cfg_beats_per_multiframe),
      .cfg_sysref_offset        (cfg_sysref_offset),
      .cfg_pulse_width          (cfg_pulse_width),
      .cfg_mf_per_pulse         (cfg_mf_per_pulse),
      .cfg_pulse_count          (cfg_pulse_count),
      .start_valid              (start_valid),
      .start_ready              (start_ready),
      .stop                     (stop),
`ifdef JESD204_SYSREF_GEN_EXT_TRIG_EN
      .ext_trigger              (ext_trigger),
`endif
      .sysref                   (sysref),
      .lmfc_edge                (lmfc_edge),
      .beat_counter             (beat_counter),
      .busy                     (busy),
      .burst_done               (burst_done),
      .pulse_index              (pulse_index)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse monitor: measures every sysref pulse and compares it with the scoreboard head.
   bit   in_pulse = 0;
   int   cur_beat, cur_len, obs_spacing, last_rise = 0, mon_cyc = 0;
   exp_t mon_e;
   always @(negedge clk) begin
      mon_cyc++;
      if (reset) begin
         in_pulse = 0;
      end else if (sysref && !in_pulse) begin
         in_pulse    = 1;
         cur_beat    = int'(beat_counter);
         cur_len     = 1;
         obs_spacing = mon_cyc - last_rise;
         last_rise   = mon_cyc;
      end else if (sysref) begin
         cur_len++;
      end else if (in_pulse) begin
         in_pulse = 0;
         chk("pulse_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("pulse_rise_beat", cur_beat, mon_e.rise_beat);
            chk("pulse_len", cur_len, mon_e.len);
            chk("pulse_spacing", (mon_e.spacing == 0) ? 0 : obs_spacing, mon_e.spacing);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input int bpm, input int off, input int w, input int mf, input int cnt);
      cfg_beats_per_multiframe = 8'(bpm);
      cfg_sysref_offset        = 8'(off);
      cfg_pulse_width          = 4'(w);
      cfg_mf_per_pulse         = 4'(mf);
      cfg_pulse_count          = 8'(cnt);
   endtask

   task automatic push(input int rb, input int len, input int sp);
      exp_t e;
      e.rise_beat = rb;
      e.len       = len;
      e.spacing   = sp;
      exp_q.push_back(e);
   endtask

   task automatic do_start();
      start_valid = 1'b1;
      tick(1);
      start_valid = 1'b0;
      chk("start_busy", busy, 1);
   endtask

   task automatic wait_beat(input int b);
      int n = 0;
      while (beat_counter != 8'(b) && n < 300) begin
         tick(1);
         n++;
      end
      chk("wait_beat", beat_counter, b);
   endtask

   task automatic wait_sysref(input logic v);
      int n = 0;
      while (sysref !== v && n < 300) begin
         tick(1);
         n++;
      end
      chk("wait_sysref", sysref, v);
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (burst_done !== 1'b1 && n < bound) begin
         tick(1);
         n++;
      end
      chk("burst_done_seen", burst_done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time=%0t, required finish before 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start_valid = 1'b0; stop = 1'b0;
      set_cfg(15, 3, 1, 0, 1);
      tick(3);
      chk("rst_beat", beat_counter, 0);
      chk("rst_sysref", sysref, 0);
      chk("rst_lmfc", lmfc_edge, 0);
      chk("rst_done", burst_done, 0);
      chk("rst_pidx", pulse_index, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", start_ready, 1);
      reset = 1'b0;
      tick(1);
      chk("run_beat1", beat_counter, 1);
      chk("lmfc_after_0", lmfc_edge, 1);
      tick(1);
      chk("lmfc_one_cycle", lmfc_edge, 0);

      // Single pulse
      wait_beat(8);
      push(4, 2, 0);
      do_start();
      chk("ready_busy", start_ready, 0);
      wait_done(100);
      chk("single_pidx", pulse_index, 1);
      chk("single_idle", busy, 0);
      tick(1);
      chk("done_one_cycle", burst_done, 0);
      chk("single_q_empty", exp_q.size(), 0);

      // Periodic burst of four
      set_cfg(15, 0, 0, 2, 4);
      push(1, 1, 0); push(1, 1, 48); push(1, 1, 48); push(1, 1, 48);
      do_start();
      chk("pidx_cleared", pulse_index, 0);
      wait_done(400);
      chk("periodic_pidx", pulse_index, 4);
      tick(1);
      chk("periodic_q_empty", exp_q.size(), 0);

      // Truncated pulses
      set_cfg(3, 0, 7, 0, 2);
      push(1, 3, 0); push(1, 3, 4);
      do_start();
      wait_done(100);
      chk("trunc_pidx", pulse_index, 2);
      tick(1);
      chk("trunc_q_empty", exp_q.size(), 0);

      // Stop on the second pulse cycle of a continuous burst
      set_cfg(15, 3, 5, 0, 0);
      push(4, 6, 0);
      do_start();
      wait_sysref(1'b1);
      tick(1);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("stop_still_high", sysref, 1);
      wait_done(50);
      chk("stop_pidx", pulse_index, 1);
      tick(40);
      chk("stop_no_more", busy, 0);
      chk("stop_q_empty", exp_q.size(), 0);

      // Stop beats start in IDLE
      start_valid = 1'b1; stop = 1'b1;
      tick(1);
      start_valid = 1'b0; stop = 1'b0;
      chk("stop_wins_busy", busy, 0);
      chk("stop_wins_ready", start_ready, 1);

      // Offset beyond the multiframe never aligns; stop from ARMED
      set_cfg(3, 9, 0, 0, 0);
      do_start();
      tick(20);
      chk("no_align_armed", busy, 1);
      chk("no_align_sysref", sysref, 0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("armed_stop_idle", busy, 0);
      chk("armed_stop_done", burst_done, 1);

      // Reset during GAP, then restart
      set_cfg(15, 5, 0, 3, 0);
      push(6, 1, 0);
      do_start();
      wait_sysref(1'b1);
      wait_sysref(1'b0);
      tick(5);
      chk("gap_busy", busy, 1);
      reset = 1'b1;
      tick(1);
      chk("rst2_beat", beat_counter, 0);
      chk("rst2_pidx", pulse_index, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_done", burst_done, 0);
      reset = 1'b0;
      tick(1);
      chk("rst2_beat1", beat_counter, 1);
      set_cfg(15, 5, 0, 0, 1);
      push(6, 1, 0);
      do_start();
      wait_done(40);
      chk("rst2_pidx_after", pulse_index, 1);
      tick(1);
      chk("rst2_q_empty", exp_q.size(), 0);

`ifdef JESD204_SYSREF_GEN_EXT_TRIG_EN
      set_cfg(15, 3, 0, 0, 1);
      push(4, 1, 0);
      ext_trigger = 1'b1;
      tick(SS);
      chk("trig_not_yet", busy, 0);
      tick(1);
      chk("trig_armed", busy, 1);
      ext_trigger = 1'b0;
      tick(4);
      ext_trigger = 1'b1;
      wait_done(60);
      tick(SS + 3);
      chk("trig_busy_ignored", busy, 0);
      chk("trig_q_empty", exp_q.size(), 0);
      ext_trigger = 1'b0;
`endif

      tick(2);
      chk("final_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
